// File: rtl/iob_uart_dbg_master.sv
// iob_uart_dbg_master: UART (8N1) command bridge acting as a 32-bit IOb bus initiator.
// Host frames: 'W' A3 A2 A1 A0 D3 D2 D1 D0 -> ACK 0x06 ; 'R' A3..A0 -> D3..D0 ; other -> NAK 0x15.
// Ports:
//   clk_i, rst_n_i            clock, synchronous active-low reset
//   bit_duration_i            clock cycles per UART bit (>= 4), latched per frame
//   rxd_i / txd_o             serial in / out, idle high
//   iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o, iob_ready_i,
//   iob_rvalid_i, iob_rdata_i IOb initiator interface
//   busy_o                    command in progress
//   err_o                     one-cycle pulse per error event
// Optional macro: IOB_UART_DBG_MASTER_TIMEOUT_EN enables a 2^20-1 cycle command timeout.
module iob_uart_dbg_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DIV_W-1:0]  bit_duration_i,
  input  logic              rxd_i,
  output logic              txd_o,
  output logic              iob_valid_o,
  output logic [ADDR_W-1:0] iob_addr_o,
  output logic [31:0]       iob_wdata_o,
  output logic [3:0]        iob_wstrb_o,
  input  logic              iob_ready_i,
  input  logic              iob_rvalid_i,
  input  logic [31:0]       iob_rdata_i,
  output logic              busy_o,
  output logic              err_o
);
  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
  localparam int unsigned TO_W   = 20;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_REQ, S_RWAIT, S_RESP} cmd_state_t;

  // RX state
  logic             r_rxd_s1, r_rxd_s2, r_rxd_prev;
  rx_state_t        r_rx_state, w_rx_nxt;
  logic [DIV_W-1:0] r_rx_cnt, r_rx_div;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_byte;
  logic             w_rx_full, w_rx_done, w_rx_ferr;

  // TX state
  logic             r_txd, r_tx_busy;
  logic [8:0]       r_tx_shift;
  logic [3:0]       r_tx_bit;
  logic [DIV_W-1:0] r_tx_cnt, r_tx_div;
  logic             w_tx_last, w_tx_load;

  // Command state
  cmd_state_t       r_cmd, w_cmd_nxt;
  logic             r_is_wr, r_valid, r_busy, r_err;
  logic [1:0]       r_byte_cnt;
  logic [31:0]      r_addr, r_wdata, r_resp;
  logic [3:0]       r_wstrb;
  logic [2:0]       r_resp_n, w_resp_n;
  logic [31:0]      w_resp_val;
  logic             w_resp_set, w_shift_addr, w_shift_data, w_err, w_timeout;

  // RX next-state: start is re-checked mid-bit, data/stop sampled at bit centres
  always_comb begin
    w_rx_nxt  = r_rx_state;
    w_rx_done = 1'b0;
    w_rx_ferr = 1'b0;
    w_rx_full = (r_rx_cnt == r_rx_div - DIV_W'(1));
    case (r_rx_state)
      RX_IDLE:  if (r_rxd_prev && !r_rxd_s2) w_rx_nxt = RX_START;
      RX_START: if (r_rx_cnt == (r_rx_div >> 1)) w_rx_nxt = r_rxd_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_full && r_rx_bit == 3'd7) w_rx_nxt = RX_STOP;
      RX_STOP: begin
        if (w_rx_full) begin
          w_rx_nxt  = RX_IDLE;
          w_rx_done = r_rxd_s2;
          w_rx_ferr = !r_rxd_s2;
        end
      end
      default:  w_rx_nxt = RX_IDLE;
    endcase
  end

  // RX registers; sync flops reset low so a high line must be seen before any start edge
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_rxd_s1   <= 1'b0;
      r_rxd_s2   <= 1'b0;
      r_rxd_prev <= 1'b0;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_div   <= '0;
      r_rx_bit   <= '0;
      r_rx_byte  <= '0;
    end else begin
      r_rxd_s1   <= rxd_i;
      r_rxd_s2   <= r_rxd_s1;
      r_rxd_prev <= r_rxd_s2;
      r_rx_state <= w_rx_nxt;
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          r_rx_bit <= '0;
          r_rx_div <= bit_duration_i;
        end
        RX_START: r_rx_cnt <= (r_rx_cnt == (r_rx_div >> 1)) ? '0 : r_rx_cnt + DIV_W'(1);
        default: begin
          if (w_rx_full) begin
            r_rx_cnt <= '0;
            if (r_rx_state == RX_DATA) begin
              r_rx_byte <= {r_rxd_s2, r_rx_byte[7:1]};
              r_rx_bit  <= r_rx_bit + 3'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + DIV_W'(1);
          end
        end
      endcase
    end
  end

  // TX: next queued byte loads on the last stop-bit cycle so bytes run back-to-back
  assign w_tx_last = r_tx_busy && (r_tx_bit == 4'd9) && (r_tx_cnt == r_tx_div - DIV_W'(1));
  assign w_tx_load = (r_cmd == S_RESP) && (r_resp_n != 3'd0) && (!r_tx_busy || w_tx_last);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_txd      <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_shift <= '1;
      r_tx_bit   <= '0;
      r_tx_cnt   <= '0;
      r_tx_div   <= '0;
    end else if (w_tx_load) begin
      r_txd      <= 1'b0;
      r_tx_busy  <= 1'b1;
      r_tx_shift <= {1'b1, r_resp[31:24]};
      r_tx_bit   <= '0;
      r_tx_cnt   <= '0;
      r_tx_div   <= bit_duration_i;
    end else if (r_tx_busy) begin
      if (r_tx_cnt == r_tx_div - DIV_W'(1)) begin
        r_tx_cnt <= '0;
        if (r_tx_bit == 4'd9) begin
          r_tx_busy <= 1'b0;
          r_txd     <= 1'b1;
        end else begin
          r_txd      <= r_tx_shift[0];
          r_tx_shift <= {1'b1, r_tx_shift[8:1]};
          r_tx_bit   <= r_tx_bit + 4'd1;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + DIV_W'(1);
      end
    end
  end

`ifdef IOB_UART_DBG_MASTER_TIMEOUT_EN
  // Command watchdog: restarts on every received byte and state change
  logic [TO_W-1:0] r_to_cnt;
  logic            w_to_run;
  assign w_to_run  = (r_cmd == S_ADDR) || (r_cmd == S_DATA) || (r_cmd == S_REQ) || (r_cmd == S_RWAIT);
  assign w_timeout = w_to_run && (r_to_cnt == {TO_W{1'b1}});
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_to_cnt <= '0;
    else if (!w_to_run || w_rx_done || (r_cmd != w_cmd_nxt)) r_to_cnt <= '0;
    else r_to_cnt <= r_to_cnt + TO_W'(1);
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Command FSM next-state
  always_comb begin
    w_cmd_nxt    = r_cmd;
    w_err        = w_rx_ferr;
    w_resp_set   = 1'b0;
    w_resp_val   = '0;
    w_resp_n     = '0;
    w_shift_addr = 1'b0;
    w_shift_data = 1'b0;
    case (r_cmd)
      S_IDLE: begin
        if (w_rx_done) begin
          if (r_rx_byte == CMD_WR || r_rx_byte == CMD_RD) begin
            w_cmd_nxt = S_ADDR;
          end else begin
            w_cmd_nxt  = S_RESP;
            w_resp_set = 1'b1;
            w_resp_val = {RSP_NAK, 24'h0};
            w_resp_n   = 3'd1;
            w_err      = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (w_rx_done) begin
          w_shift_addr = 1'b1;
          if (r_byte_cnt == 2'd3) w_cmd_nxt = r_is_wr ? S_DATA : S_REQ;
        end
      end
      S_DATA: begin
        if (w_rx_done) begin
          w_shift_data = 1'b1;
          if (r_byte_cnt == 2'd3) w_cmd_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_err = w_rx_ferr || w_rx_done;
        if (iob_ready_i) begin
          if (r_is_wr) begin
            w_cmd_nxt  = S_RESP;
            w_resp_set = 1'b1;
            w_resp_val = {RSP_ACK, 24'h0};
            w_resp_n   = 3'd1;
          end else begin
            w_cmd_nxt = S_RWAIT;
          end
        end
      end
      S_RWAIT: begin
        w_err = w_rx_ferr || w_rx_done;
        if (iob_rvalid_i) begin
          w_cmd_nxt  = S_RESP;
          w_resp_set = 1'b1;
          w_resp_val = iob_rdata_i;
          w_resp_n   = 3'd4;
        end
      end
      S_RESP: begin
        w_err = w_rx_ferr || w_rx_done;
        if (w_tx_last && r_resp_n == 3'd0) w_cmd_nxt = S_IDLE;
      end
      default: w_cmd_nxt = S_IDLE;
    endcase
    if (w_timeout) begin
      w_cmd_nxt  = S_RESP;
      w_resp_set = 1'b1;
      w_resp_val = {RSP_NAK, 24'h0};
      w_resp_n   = 3'd1;
      w_err      = 1'b1;
    end
  end

  // Command FSM registers and bus-side outputs
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_cmd      <= S_IDLE;
      r_is_wr    <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_byte_cnt <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_resp     <= '0;
      r_resp_n   <= '0;
    end else begin
      r_cmd   <= w_cmd_nxt;
      r_valid <= (w_cmd_nxt == S_REQ);
      r_busy  <= (w_cmd_nxt != S_IDLE);
      r_err   <= w_err;
      if (r_cmd != w_cmd_nxt) r_byte_cnt <= '0;
      else if (w_rx_done) r_byte_cnt <= r_byte_cnt + 2'd1;
      if (r_cmd == S_IDLE && w_rx_done) r_is_wr <= (r_rx_byte == CMD_WR);
      if (w_shift_addr) r_addr <= {r_addr[23:0], r_rx_byte};
      if (w_shift_data) r_wdata <= {r_wdata[23:0], r_rx_byte};
      if (w_cmd_nxt == S_REQ && r_cmd != S_REQ) r_wstrb <= r_is_wr ? 4'hF : 4'h0;
      if (w_resp_set) begin
        r_resp   <= w_resp_val;
        r_resp_n <= w_resp_n;
      end else if (w_tx_load) begin
        r_resp   <= {r_resp[23:0], 8'h00};
        r_resp_n <= r_resp_n - 3'd1;
      end
    end
  end

  assign txd_o       = r_txd;
  assign iob_valid_o = r_valid;
  assign iob_addr_o  = r_addr[ADDR_W-1:0];
  assign iob_wdata_o = r_wdata;
  assign iob_wstrb_o = r_wstrb;
  assign busy_o      = r_busy;
  assign err_o       = r_err;
endmodule

// File: tb/tb_iob_uart_dbg_master.sv
// Bench for iob_uart_dbg_master: UART host driver, IOb target responder, TX decoder
// and a frame-level model of the expected bus request and reply bytes.
module tb_iob_uart_dbg_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bdur = 16'd16;
  logic        rxd = 1'b1;
  logic        txd;
  logic        valid;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        ready = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        busy, err;

  always #5 clk = ~clk;

  iob_uart_dbg_master dut (
    .clk_i(clk), .rst_n_i(rst_n), .bit_duration_i(bdur), .rxd_i(rxd), .txd_o(txd),
    .iob_valid_o(valid), .iob_addr_o(addr), .iob_wdata_o(wdata), .iob_wstrb_o(wstrb),
    .iob_ready_i(ready), .iob_rvalid_i(rvalid), .iob_rdata_i(rdata),
    .busy_o(busy), .err_o(err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int bd = 16;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus/err monitor
  int req_cnt = 0, valid_cyc = 0, err_cyc = 0, unstable = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0]  req_wstrb = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] prev_addr = 0, prev_wdata = 0;
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cyc++;
      if (prev_valid !== 1'b1) begin
        req_cnt++;
        req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
      end else if (addr !== prev_addr || wdata !== prev_wdata) begin
        unstable++;
      end
    end
    if (err === 1'b1) err_cyc++;
    prev_valid = valid; prev_addr = addr; prev_wdata = wdata;
  end

  // IOb target: ready after rdly cycles, rvalid vdly cycles after acceptance
  logic        resp_en = 1'b1;
  int          rdly = 0, vdly = 1;
  logic [31:0] rd_val = 0;
  always begin
    @(negedge clk);
    if (valid === 1'b1 && resp_en) begin
      repeat (rdly) @(negedge clk);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
      repeat (vdly - 1) @(negedge clk);
      rvalid = 1'b1;
      rdata  = (wstrb == 4'h0) ? rd_val : 32'hBAD0_BAD0;
      @(negedge clk);
      rvalid = 1'b0;
      rdata  = $urandom();
    end
  end

  // UART decoder on txd
  logic [7:0] tx_q[$];
  int         tx_t[$];
  int         tx_stop_bad = 0;
  logic       txd_prev = 1'b1;
  always begin
    logic [7:0] b;
    int t0;
    @(negedge clk);
    if (txd_prev === 1'b1 && txd === 1'b0) begin
      t0 = cyc;
      repeat (bd / 2) @(negedge clk);
      b = 8'h00;
      for (int i = 0; i < 8; i++) begin
        repeat (bd) @(negedge clk);
        b[i] = txd;
      end
      repeat (bd) @(negedge clk);
      if (txd !== 1'b1) tx_stop_bad++;
      tx_q.push_back(b);
      tx_t.push_back(t0);
    end
    txd_prev = txd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v, input int gap);
    rxd = 1'b0;
    repeat (bd) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (bd) @(negedge clk);
    end
    rxd = stop_v;
    repeat (bd) @(negedge clk);
    rxd = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    int c = 0;
    while (tx_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (tx_q.size() >= n);
  endtask

  task automatic set_bd(input int v);
    bd   = v;
    bdur = 16'(v);
  endtask

  // One host command; ferr_pos > 0 inserts a stop=0 garbage byte before frame byte ferr_pos
  task automatic run_txn(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rv, input int rd, input int vd, input int ferr_pos);
    logic [7:0] frame[$];
    logic [7:0] exp_q[$];
    bit         exp_req, ok;
    logic [3:0] exp_ws;
    int         exp_err, req0, vc0, e0, sb0;
    frame = {cmd};
    exp_q = {};
    exp_req = 1'b0; exp_ws = 4'h0; exp_err = 0;
    if (cmd == 8'h57 || cmd == 8'h52) begin
      exp_req = 1'b1;
      for (int k = 3; k >= 0; k--) frame.push_back(a[8*k +: 8]);
      if (cmd == 8'h57) begin
        for (int k = 3; k >= 0; k--) frame.push_back(d[8*k +: 8]);
        exp_q.push_back(8'h06);
        exp_ws = 4'hF;
      end else begin
        for (int k = 3; k >= 0; k--) exp_q.push_back(rv[8*k +: 8]);
      end
    end else begin
      exp_q.push_back(8'h15);
      exp_err = 1;
    end
    if (ferr_pos > 0 && ferr_pos < frame.size()) exp_err++;
    rdly = rd; vdly = vd; rd_val = rv;
    tx_q.delete(); tx_t.delete();
    req0 = req_cnt; vc0 = valid_cyc; e0 = err_cyc; sb0 = tx_stop_bad;
    foreach (frame[i]) begin
      if (i == ferr_pos) begin
        send_byte(8'($urandom()), 1'b0, 0);
        repeat (2 * bd) @(negedge clk);
      end
      send_byte(frame[i], 1'b1, $urandom_range(0, bd));
    end
    wait_bytes(exp_q.size(), 50 * bd + 2000, ok);
    repeat (bd + 4) @(negedge clk);
    chk("resp_done", 32'(ok), 32'd1);
    chk("resp_len", 32'(tx_q.size()), 32'(exp_q.size()));
    foreach (exp_q[k])
      chk($sformatf("resp_byte%0d", k), (k < tx_q.size()) ? 32'(tx_q[k]) : 32'hxxxx_xxxx, 32'(exp_q[k]));
    for (int k = 1; k < tx_t.size(); k++)
      chk("no_gap", 32'(tx_t[k] - tx_t[k-1]), 32'(10 * bd));
    chk("stop_bits", 32'(tx_stop_bad - sb0), 32'd0);
    chk("req_count", 32'(req_cnt - req0), 32'(exp_req));
    chk("err_pulses", 32'(err_cyc - e0), 32'(exp_err));
    if (exp_req) begin
      chk("req_addr", req_addr, a);
      chk("req_wstrb", 32'(req_wstrb), 32'(exp_ws));
      chk("valid_cycles", 32'(valid_cyc - vc0), 32'(rd + 1));
      if (cmd == 8'h57) chk("req_wdata", req_wdata, d);
    end
    chk("busy_idle", 32'(busy), 32'd0);
    chk("req_stable", 32'(unstable), 32'd0);
  endtask

  initial begin
    bit ok;
    int c, e0, r0;
    logic [7:0] rc;

    // Reset state
    set_bd(16);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_wstrb", 32'(wstrb), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (5) @(negedge clk);

    // Directed: write, read, bad command, framing errors
    run_txn(8'h57, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 3, 1, -1);
    run_txn(8'h52, 32'h0000_0020, 32'h0, 32'h1234_5678, 0, 5, -1);
    run_txn(8'h41, 32'h0, 32'h0, 32'h0, 0, 1, -1);
    run_txn(8'h52, 32'hCAFE_0004, 32'h0, 32'h0BAD_F00D, 1, 1, 2);
    run_txn(8'h57, 32'h0000_0008, 32'h5555_AAAA, 32'h0, 0, 2, 4);

    // Reset while a request is pending with ready held low
    set_bd(12);
    resp_en = 1'b0;
    send_byte(8'h57, 1'b1, 0);
    for (int k = 0; k < 8; k++) send_byte(8'(k + 1), 1'b1, 0);
    c = 0;
    while (valid !== 1'b1 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("req_pending", 32'(valid), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_valid", 32'(valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_txd", 32'(txd), 32'd1);
    resp_en = 1'b1;
    repeat (5) @(negedge clk);
    run_txn(8'h57, 32'h0000_0040, 32'h0102_0304, 32'h0, 2, 1, -1);

    // Randomized commands against the frame model
    for (int n = 0; n < 10; n++) begin
      set_bd($urandom_range(6, 14));
      c = $urandom_range(0, 9);
      if (c < 4) rc = 8'h57;
      else if (c < 8) rc = 8'h52;
      else begin
        do rc = 8'($urandom()); while (rc == 8'h57 || rc == 8'h52);
      end
      run_txn(rc, $urandom(), $urandom(), $urandom(), $urandom_range(0, 4),
              $urandom_range(1, 6), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : -1);
    end

    // Abandoned command
    set_bd(10);
    e0 = err_cyc; r0 = req_cnt;
    tx_q.delete(); tx_t.delete();
    send_byte(8'h57, 1'b1, 0);
    send_byte(8'h00, 1'b1, 0);
`ifdef IOB_UART_DBG_MASTER_TIMEOUT_EN
    wait_bytes(1, (1 << 20) + 60 * bd, ok);
    repeat (bd + 4) @(negedge clk);
    chk("to_done", 32'(ok), 32'd1);
    chk("to_nak", (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'hxxxx_xxxx, 32'h15);
    chk("to_err", 32'(err_cyc - e0), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
`else
    repeat (3000) @(negedge clk);
    chk("stuck_busy", 32'(busy), 32'd1);
    chk("stuck_err", 32'(err_cyc - e0), 32'd0);
    chk("stuck_tx", 32'(tx_q.size()), 32'd0);
`endif
    chk("stuck_req", 32'(req_cnt - r0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/iob_uart_dbg_master.md
# iob_uart_dbg_master

Serial-to-IOb bridge: receives 8N1 UART command frames from an external host, executes one 32-bit IOb read or write per frame as bus initiator, and returns the result over UART. Sits at the host end of the same serial link an `iob_uart` peripheral serves. It gives a debug/bootstrap path into the SoC bus without a CPU.

## Interface
Parameters:
- ADDR_W, 32, IOb address width (1..32); the low ADDR_W bits of the received 32-bit address are used.
- DIV_W, 16, width of bit_duration_i.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- bit_duration_i  in  DIV_W  clock cycles per UART bit; values < 4 are illegal; sampled at each frame start.
- rxd_i  in  1  serial input, idle high.
- txd_o  out  1  serial output, idle high.
- iob_valid_o  out  1  bus request.
- iob_addr_o  out  ADDR_W  request address.
- iob_wdata_o  out  32  write data.
- iob_wstrb_o  out  4  4'hF = write, 4'h0 = read.
- iob_ready_i  in  1  request accepted.
- iob_rvalid_i  in  1  read data valid.
- iob_rdata_i  in  32  read data.
- busy_o  out  1  high from first command byte until response stop bit ends.
- err_o  out  1  one-cycle pulse per error event.

## Operation
- RX: rxd_i passes a 2-flop synchronizer. Falling edge starts a frame; start is re-sampled at bit_duration_i/2 and the frame is aborted if high. The 8 data bits (LSB first) and stop bit are sampled at bit centers. Stop = 0 means framing error: byte dropped, err_o pulses.
- Command FSM states: IDLE, ADDR, DATA, REQ, RWAIT, RESP.
  - IDLE: byte 0x57 ('W') -> ADDR (write); 0x52 ('R') -> ADDR (read); any other byte -> send 0x15 (NAK) via RESP, err_o pulses.
  - ADDR: 4 bytes, MSB first -> DATA (write) or REQ (read).
  - DATA: 4 bytes, MSB first -> REQ.
  - REQ: iob_valid_o high, address/wdata/wstrb stable until iob_ready_i sampled high. Write -> RESP with 0x06 (ACK). Read -> RWAIT.
  - RWAIT: capture iob_rdata_i on iob_rvalid_i -> RESP with 4 bytes, MSB first.
  - RESP: transmit queued bytes back-to-back, then IDLE.
- TX: start bit 0, 8 data bits LSB first, stop bit 1, each lasting bit_duration_i cycles.
- Bytes completing while in REQ/RWAIT/RESP are dropped and err_o pulses.
- iob_rvalid_i outside RWAIT is ignored. iob_ready_i outside REQ is ignored.

## Timing
- Reset values: txd_o=1, iob_valid_o=0, iob_addr_o=0, iob_wdata_o=0, iob_wstrb_o=0, busy_o=0, err_o=0, FSM=IDLE, RX/TX idle.
- iob_valid_o rises the cycle after the final command byte's stop-bit sample. It falls the cycle after iob_ready_i=1. Same-cycle ready is allowed: valid is high exactly 1 cycle.
- For reads, iob_rvalid_i in the cycle after acceptance is legal. No upper latency bound unless timeout is compiled in.
- The TX start bit begins the cycle after entering RESP. Consecutive response bytes have no idle gap.
- busy_o rises the cycle after a valid command byte's stop sample. It falls the cycle after the final stop bit.
- A reset asserted mid-operation aborts everything at that edge: iob_valid_o drops even without ready, and txd_o returns to 1 immediately.
- After reset the receiver waits for rxd_i high (synchronized) before accepting a start edge.

## Configuration
- IOB_UART_DBG_MASTER_TIMEOUT_EN defined:
  - A 20-bit counter runs in ADDR, DATA, REQ and RWAIT and clears on each received byte or state change.
  - On reaching 2^20−1 cycles: iob_valid_o drops, NAK 0x15 is sent, err_o pulses, then IDLE.
- Macro undefined: no counter; these states wait indefinitely.

## Test plan
- Write (bit_duration_i=16): send 57 00 00 10 00 DE AD BE EF, ready after 3 cycles -> one request with iob_addr_o=0x1000, iob_wdata_o=0xDEADBEEF, iob_wstrb_o=F, valid high 4 cycles; txd_o returns 0x06.
- Read: send 52 00 00 00 20, ready same cycle, rvalid 5 cycles later with 0x12345678 -> iob_wstrb_o=0; txd_o returns 12 34 56 78 with no inter-byte gap.
- Bad command 0x41 -> txd_o returns 0x15; err_o pulses once; no iob_valid_o.
- Framing error: address byte sent with stop=0 -> err_o pulse; byte ignored; next 4 good bytes complete the address.
- Reset during REQ (ready held low) with rst_n_i=0 for 1 cycle -> iob_valid_o=0 and busy_o=0 at that edge; a new write then succeeds.
- Timeout build: send 57 00 then stop -> after 2^20−1 cycles, 0x15 sent and err_o pulses; non-timeout build stays busy.
